vrased_reset_ctrl: RTL and testbench

- Consumer end of the security-monitor kill protocol.
- Collects level-type kill requests from the monitors (stack/data-access monitor, atomicity monitor, key-access monitor, spare), and drives a stretched reset into the MSP430 core.
- Holds the core in reset until it re-enters at the reset handler. Monitors only leave their kill state once pc reaches the reset handler.
- Records the violation cause and count in sticky, software-readable peripheral registers for post-reset attestation reporting.

---
 rtl/vrased_reset_ctrl_pkg.sv | 25 ++
 rtl/rst_ctrl_regs.sv | 60 ++++++
 rtl/vrased_reset_ctrl.sv | 134 +++++++++++++
 tb/tb_vrased_reset_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared constants for the VRASED reset controller: peripheral register map,
// FSM state encoding and monitor kill-source indices.
package vrased_reset_ctrl_pkg;

  localparam logic [13:0] RST_CTRL_BASE      = 14'h0190;
  localparam logic [13:0] RST_CTRL_CAUSE_OFS = 14'd0;
  localparam logic [13:0] RST_CTRL_COUNT_OFS = 14'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } rst_state_t;

  localparam int SRC_XSTACK = 0;
  localparam int SRC_ATOMIC = 1;
  localparam int SRC_KEYAC  = 2;
  localparam int SRC_SPARE  = 3;

  // The violation counter sticks at its maximum rather than wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rst_ctrl_regs.sv
// Sticky CAUSE / saturating COUNT peripheral registers of the reset controller,
// with write-1-to-clear on CAUSE and the combinational read mux.
module rst_ctrl_regs
  import vrased_reset_ctrl_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [13:0] BASE_ADDR = RST_CTRL_BASE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] set_cause,
  input  logic               inc_count,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  output logic [15:0]        per_dout
);

  logic [NUM_SRC-1:0] cause_q;
  logic [7:0]         count_q;
  logic               wr_en;
  logic               rd_en;
  logic               sel_cause;
  logic               sel_count;
  logic [NUM_SRC-1:0] clr_mask;
  logic               unused_din;

  assign wr_en     = per_en && (per_we != 2'b00);
  assign rd_en     = per_en && (per_we == 2'b00);
  assign sel_cause = (per_addr == (BASE_ADDR + RST_CTRL_CAUSE_OFS));
  assign sel_count = (per_addr == (BASE_ADDR + RST_CTRL_COUNT_OFS));
  assign clr_mask  = (wr_en && sel_cause) ? per_din[NUM_SRC-1:0] : '0;
  assign unused_din = ^per_din[15:NUM_SRC];

  // A set arriving on the same edge as a W1C write must survive it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= '0;
      count_q <= 8'h00;
    end else begin
      cause_q <= (cause_q & ~clr_mask) | set_cause;
      if (wr_en && sel_count) begin
        count_q <= inc_count ? 8'h01 : 8'h00;
      end else if (inc_count) begin
        count_q <= sat_inc8(count_q);
      end
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (rd_en && sel_cause) begin
      per_dout = 16'(cause_q);
    end else if (rd_en && sel_count) begin
      per_dout = {8'h00, count_q};
    end
  end

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Consumer end of the security-monitor kill protocol: stretches a reset into
// the core and holds it until the core is seen re-entering at the reset vector.
module vrased_reset_ctrl
  import vrased_reset_ctrl_pkg::*;
#(
  parameter int          NUM_SRC       = 4,
  parameter int          STRETCH       = 8,
  parameter int          WAIT_MAX      = 64,
  parameter logic [15:0] RESET_HANDLER = 16'hfffe,
  parameter logic [13:0] BASE_ADDR     = RST_CTRL_BASE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] viol_req,
  input  logic [15:0]        pc,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  output logic [15:0]        per_dout,
  output logic               cpu_rst,
  output logic               busy
);

  localparam int SCW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [SCW-1:0] STRETCH_LOAD = SCW'(STRETCH - 1);
  localparam logic [WCW-1:0] WAIT_LAST    = WCW'(WAIT_MAX - 1);

  rst_state_t         state_q, state_d;
  logic [SCW-1:0]     stretch_q, stretch_d;
  logic [WCW-1:0]     wait_q, wait_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               seen_q, seen_d;
  logic               cpu_rst_q;
  logic [NUM_SRC-1:0] new_src;
  logic               seen_now;
  logic [NUM_SRC-1:0] set_cause;
  logic               inc_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      stretch_q <= '0;
      wait_q    <= '0;
      mask_q    <= '0;
      seen_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      wait_q    <= wait_d;
      mask_q    <= mask_d;
      seen_q    <= seen_d;
      cpu_rst_q <= (state_d == HOLD);
    end
  end

  assign new_src  = viol_req & ~mask_q;
  assign seen_now = seen_q || (pc == RESET_HANDLER);

  // Priority: new source re-hold, then wait-window expiry, then return to IDLE
  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    wait_d    = wait_q;
    mask_d    = mask_q;
    seen_d    = seen_q;
    set_cause = '0;
    inc_count = 1'b0;
    case (state_q)
      IDLE: begin
        if (|viol_req) begin
          state_d   = HOLD;
          mask_d    = viol_req;
          set_cause = viol_req;
          inc_count = 1'b1;
          stretch_d = STRETCH_LOAD;
        end
      end
      HOLD: begin
        if (|new_src) begin
          mask_d    = mask_q | new_src;
          set_cause = new_src;
          stretch_d = STRETCH_LOAD;
        end else if (stretch_q == '0) begin
          state_d = RELEASE;
          wait_d  = '0;
          seen_d  = 1'b0;
        end else begin
          stretch_d = stretch_q - SCW'(1);
        end
      end
      RELEASE: begin
        seen_d = seen_now;
        if (|new_src) begin
          state_d   = HOLD;
          mask_d    = mask_q | new_src;
          set_cause = new_src;
          stretch_d = STRETCH_LOAD;
        end else if ((wait_q == WAIT_LAST) && (!seen_now || (|viol_req))) begin
          state_d   = HOLD;
          stretch_d = STRETCH_LOAD;
        end else if (!(|viol_req) && seen_now) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rst = cpu_rst_q;
  assign busy    = (state_q != IDLE);

  rst_ctrl_regs #(
    .NUM_SRC   (NUM_SRC),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_cause (set_cause),
    .inc_count (inc_count),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout)
  );

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Self-checking bench for vrased_reset_ctrl: directed episodes plus random
// traffic, compared against an episode-level behavioural model.
module tb_vrased_reset_ctrl;

  localparam int          NUM_SRC  = 4;
  localparam int          STRETCH  = 8;
  localparam int          WAIT_MAX = 64;
  localparam logic [15:0] HANDLER  = 16'hfffe;
  localparam logic [13:0] BASE     = 14'h0190;

  logic               clk      = 1'b0;
  logic               reset_n  = 1'b0;
  logic [NUM_SRC-1:0] viol_req = '0;
  logic [15:0]        pc       = '0;
  logic [13:0]        per_addr = '0;
  logic [15:0]        per_din  = '0;
  logic               per_en   = 1'b0;
  logic [1:0]         per_we   = '0;
  logic [15:0]        per_dout;
  logic               cpu_rst;
  logic               busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: phase name, remaining hold cycles, cycles spent in release
  string              m_phase     = "IDLE";
  int                 m_hold_left = 0;
  int                 m_age       = 0;
  bit                 m_seen      = 1'b0;
  logic [NUM_SRC-1:0] m_mask      = '0;
  logic [NUM_SRC-1:0] m_cause     = '0;
  int                 m_count     = 0;

  always #5 clk = ~clk;

  vrased_reset_ctrl #(
    .NUM_SRC       (NUM_SRC),
    .STRETCH       (STRETCH),
    .WAIT_MAX      (WAIT_MAX),
    .RESET_HANDLER (HANDLER),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .viol_req (viol_req),
    .pc       (pc),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .cpu_rst  (cpu_rst),
    .busy     (busy)
  );

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] modelRead();
    if (!per_en || per_we != 2'b00) return 16'h0000;
    if (per_addr == BASE) return {12'h000, m_cause};
    if (per_addr == BASE + 14'd1) return {8'h00, 8'(m_count)};
    return 16'h0000;
  endfunction

  task automatic modelReset();
    m_phase = "IDLE"; m_hold_left = 0; m_age = 0; m_seen = 1'b0;
    m_mask = '0; m_cause = '0; m_count = 0;
  endtask

  task automatic enterHold(input logic [NUM_SRC-1:0] added, output logic [NUM_SRC-1:0] setb);
    m_phase     = "HOLD";
    m_mask      = m_mask | added;
    setb        = added;
    m_hold_left = STRETCH;
  endtask

  task automatic modelEdge();
    logic [NUM_SRC-1:0] fresh;
    logic [NUM_SRC-1:0] setb;
    bit inc;
    bit wr;
    fresh = viol_req & ~m_mask;
    setb  = '0;
    inc   = 1'b0;
    wr    = per_en && (per_we != 2'b00);
    if (m_phase == "IDLE") begin
      if (viol_req != 0) begin
        m_mask = '0;
        enterHold(viol_req, setb);
        inc = 1'b1;
      end
    end else if (m_phase == "HOLD") begin
      if (fresh != 0) begin
        enterHold(fresh, setb);
      end else begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_phase = "RELEASE"; m_age = 0; m_seen = 1'b0;
        end
      end
    end else begin
      m_seen = m_seen || (pc == HANDLER);
      if (fresh != 0) begin
        enterHold(fresh, setb);
      end else if (m_age == WAIT_MAX - 1 && (!m_seen || viol_req != 0)) begin
        m_phase = "HOLD"; m_hold_left = STRETCH;
      end else if (viol_req == 0 && m_seen) begin
        m_phase = "IDLE";
      end else begin
        m_age++;
      end
    end
    m_cause = (m_cause & ~((wr && per_addr == BASE) ? per_din[NUM_SRC-1:0] : 4'h0)) | setb;
    if (wr && per_addr == BASE + 14'd1) m_count = inc ? 1 : 0;
    else if (inc && m_count < 255) m_count++;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] v, input logic [15:0] p,
                               input logic [13:0] a, input logic [15:0] d,
                               input logic en, input logic [1:0] we);
    viol_req = v; pc = p; per_addr = a; per_din = d; per_en = en; per_we = we;
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, " cpu_rst"}, {15'h0, cpu_rst}, {15'h0, (m_phase == "HOLD")});
    checkEq({tag, " busy"}, {15'h0, busy}, {15'h0, (m_phase != "IDLE")});
  endtask

  task automatic step(input string tag);
    #1;
    if (per_en && per_we == 2'b00) checkEq({tag, " per_dout"}, per_dout, modelRead());
    @(posedge clk);
    modelEdge();
    cyc++;
    #1 checkOutput(tag);
  endtask

  task automatic runRead(input string tag, input logic [NUM_SRC-1:0] v,
                         input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(v, p, BASE + 14'(cyc % 2), 16'h0000, 1'b1, 2'b00);
      step(tag);
    end
  endtask

  task automatic runWrite(input string tag, input logic [NUM_SRC-1:0] v, input logic [15:0] p,
                          input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    applyStimulus(v, p, a, d, 1'b1, we);
    step(tag);
  endtask

  task automatic readConst(input string tag, input logic [13:0] a, input logic [15:0] exp);
    applyStimulus(viol_req, pc, a, 16'h0000, 1'b1, 2'b00);
    #1 checkEq(tag, per_dout, exp);
  endtask

  initial begin
    logic [NUM_SRC-1:0] rv;
    rv = '0;
    #10;
    readConst("por cause", BASE, 16'h0000);
    readConst("por count", BASE + 14'd1, 16'h0000);
    checkOutput("por");
    #1 reset_n = 1'b1;

    runRead("idle", 4'h0, 16'h0000, 20);
    readConst("idle cause", BASE, 16'h0000);
    readConst("idle count", BASE + 14'd1, 16'h0000);

    runRead("ep1", 4'h1, 16'h1234, 12);
    runRead("ep1", 4'h1, HANDLER, 1);
    runRead("ep1", 4'h0, 16'h0000, 4);
    readConst("ep1 cause", BASE, 16'h0001);
    readConst("ep1 count", BASE + 14'd1, 16'h0001);

    runRead("extend", 4'h1, 16'h1234, 5);
    runRead("extend", 4'h5, 16'h1234, 14);
    runRead("extend", 4'h5, HANDLER, 1);
    runRead("extend", 4'h0, 16'h0000, 4);
    readConst("extend cause", BASE, 16'h0005);
    readConst("extend count", BASE + 14'd1, 16'h0002);

    runRead("retry", 4'h2, 16'h4000, 10);
    runRead("retry", 4'h0, 16'h4000, 80);
    runRead("retry", 4'h0, HANDLER, 3);
    readConst("retry cause", BASE, 16'h0007);
    readConst("retry count", BASE + 14'd1, 16'h0003);

    runWrite("w1c", 4'h0, 16'h0000, BASE, 16'h000f, 2'b01);
    runWrite("setwins", 4'h1, 16'h1234, BASE, 16'h0001, 2'b11);
    runRead("setwins", 4'h0, HANDLER, 12);
    readConst("setwins cause", BASE, 16'h0001);
    runWrite("clr", 4'h0, 16'h0000, BASE, 16'h0001, 2'b10);
    readConst("clr cause", BASE, 16'h0000);
    runWrite("cntclr", 4'h0, 16'h0000, BASE + 14'd1, 16'h1234, 2'b01);
    readConst("cntclr count", BASE + 14'd1, 16'h0000);

    for (int e = 0; e < 300; e++) begin
      runRead("sat", 4'h1, 16'h1234, 1);
      runRead("sat", 4'h0, HANDLER, 11);
    end
    readConst("sat count", BASE + 14'd1, 16'h00ff);

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] rp;
      logic [13:0] ra;
      if ($urandom_range(15) == 0) rv = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom);
      rp = ($urandom_range(5) == 0) ? HANDLER : 16'($urandom);
      ra = BASE + 14'($urandom_range(2));
      if ($urandom_range(4) == 0) applyStimulus(rv, rp, ra, 16'($urandom), 1'b1, 2'($urandom_range(3, 1)));
      else applyStimulus(rv, rp, ra, 16'h0000, 1'($urandom), 2'b00);
      step("rand");
    end

    runRead("drain", 4'h0, HANDLER, 30);
    runRead("prereset", 4'h8, 16'h1234, 3);
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput("async");
    readConst("async cause", BASE, 16'h0000);
    readConst("async count", BASE + 14'd1, 16'h0000);
    reset_n = 1'b1;
    runRead("postreset", 4'h0, 16'h0000, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
